// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM-stage data cache.
// Holds the controller state encoding, default geometry of the cache and
// the bit position where the line index starts inside a byte address.
// Ports: none (package).
package mem_stage_pkg;

  localparam int NUM_LINES_DEF = 16;
  localparam int INDEX_W_DEF   = 4;
  localparam int TAG_W_DEF     = 30 - INDEX_W_DEF;

  // Bits [1:0] select a byte inside the word and are ignored by the cache,
  // so the line index starts here and the tag starts at INDEX_LSB+INDEX_W.
  localparam int INDEX_LSB = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2,
    WDONE = 2'd3
  } state_t;

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage for the direct-mapped data cache.
// Ports:
//   clock, reset              rising-edge clock, synchronous active-high reset
//   rd_idx -> rd_valid/rd_tag/rd_data   combinational lookup port
//   we, wr_idx, wr_tag, wr_data, wr_set_valid   single synchronous write port
// Reset clears only the valid bits; tag and data contents are don't-care
// while their valid bit is low.
module dcache_array
  import mem_stage_pkg::*;
#(
  parameter int NUM_LINES = NUM_LINES_DEF,
  parameter int INDEX_W   = INDEX_W_DEF,
  parameter int TAG_W     = TAG_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [INDEX_W-1:0] rd_idx,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [31:0]        rd_data,
  input  logic               we,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [31:0]        wr_data,
  input  logic               wr_set_valid
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES];

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
    end else if (we) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
      if (wr_set_valid) valid_q[wr_idx] <= 1'b1;
    end
  end

endmodule

// File: rtl/dcache_mem_stage.sv
// MEM-stage data cache: direct-mapped, write-through, no-write-allocate,
// one 32-bit word per line. Read hits answer combinationally; read misses
// and every store stall the pipeline while main memory is accessed over a
// request/ready handshake.
// Ports:
//   clockPulse, reset          clock and synchronous active-high reset
//   MemRead, MemWrite, address, writeData   request from EX/MEM
//   hit, readData              result to MEM/WB
//   stall                      freeze upstream stages
//   memRead, memWrite, memAddr, memWriteData, memReadData, memReady
//                              main-memory interface
//   hitCount, missCount        read hit/miss counters, present only when
//                              DCACHE_STATS_EN is defined
module dcache_mem_stage
  import mem_stage_pkg::*;
#(
  parameter int NUM_LINES = NUM_LINES_DEF,
  parameter int INDEX_W   = INDEX_W_DEF,
  parameter int TAG_W     = TAG_W_DEF
) (
  input  logic        clockPulse,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic        hit,
  output logic [31:0] readData,
  output logic        stall,
  output logic        memRead,
  output logic        memWrite,
  output logic [31:0] memAddr,
  output logic [31:0] memWriteData,
  input  logic [31:0] memReadData,
  input  logic        memReady
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0] hitCount,
  output logic [15:0] missCount
`endif
);

  state_t state_q, state_d;

  logic [31:0] lat_addr_q, lat_data_q;
  logic        latch_addr, latch_data;
  logic        count_hit, count_miss;

  logic [INDEX_W-1:0] req_idx, lat_idx;
  logic [TAG_W-1:0]   req_tag, lat_tag;

  logic               rd_valid;
  logic [TAG_W-1:0]   rd_tag;
  logic [31:0]        rd_data;
  logic               lookup_hit;

  logic               we;
  logic [INDEX_W-1:0] wr_idx;
  logic [TAG_W-1:0]   wr_tag;
  logic [31:0]        wr_data;

  // Byte-offset bits never take part in a lookup.
  logic unused_offset;
  assign unused_offset = ^address[INDEX_LSB-1:0];

  assign req_idx = address[INDEX_W+INDEX_LSB-1:INDEX_LSB];
  assign req_tag = address[31:INDEX_W+INDEX_LSB];
  assign lat_idx = lat_addr_q[INDEX_W+INDEX_LSB-1:INDEX_LSB];
  assign lat_tag = lat_addr_q[31:INDEX_W+INDEX_LSB];

  assign lookup_hit   = rd_valid && (rd_tag == req_tag);
  assign memAddr      = lat_addr_q;
  assign memWriteData = lat_data_q;

  dcache_array #(
    .NUM_LINES(NUM_LINES),
    .INDEX_W  (INDEX_W),
    .TAG_W    (TAG_W)
  ) u_array (
    .clock       (clockPulse),
    .reset       (reset),
    .rd_idx      (req_idx),
    .rd_valid    (rd_valid),
    .rd_tag      (rd_tag),
    .rd_data     (rd_data),
    .we          (we),
    .wr_idx      (wr_idx),
    .wr_tag      (wr_tag),
    .wr_data     (wr_data),
    .wr_set_valid(1'b1)
  );

  // State register plus the latched memory request; reset abandons any
  // in-flight transaction so a late memReady lands in IDLE and is ignored.
  always_ff @(posedge clockPulse) begin
    if (reset) begin
      state_q    <= IDLE;
      lat_addr_q <= '0;
      lat_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch_addr) lat_addr_q <= {address[31:2], 2'b00};
      if (latch_data) lat_data_q <= writeData;
    end
  end

  // Next state, pipeline/memory outputs and the array write port.
  // A store that hits rewrites the line with its own tag, which keeps the
  // line valid. The request side is masked while reset is held so no
  // lookup can raise stall during reset.
  always_comb begin
    state_d    = state_q;
    hit        = 1'b0;
    readData   = '0;
    stall      = 1'b0;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    latch_addr = 1'b0;
    latch_data = 1'b0;
    count_hit  = 1'b0;
    count_miss = 1'b0;
    we         = 1'b0;
    wr_idx     = req_idx;
    wr_tag     = req_tag;
    wr_data    = writeData;

    case (state_q)
      IDLE: begin
        if (!reset) begin
          if (MemWrite) begin
            stall      = 1'b1;
            latch_addr = 1'b1;
            latch_data = 1'b1;
            we         = lookup_hit;
            state_d    = WRITE;
          end else if (MemRead) begin
            if (lookup_hit) begin
              hit       = 1'b1;
              readData  = rd_data;
              count_hit = 1'b1;
            end else begin
              stall      = 1'b1;
              latch_addr = 1'b1;
              count_miss = 1'b1;
              state_d    = FETCH;
            end
          end
        end
      end
      FETCH: begin
        memRead = 1'b1;
        stall   = 1'b1;
        if (memReady) begin
          we      = 1'b1;
          wr_idx  = lat_idx;
          wr_tag  = lat_tag;
          wr_data = memReadData;
          state_d = IDLE;
        end
      end
      WRITE: begin
        memWrite = 1'b1;
        stall    = 1'b1;
        if (memReady) state_d = WDONE;
      end
      WDONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef DCACHE_STATS_EN
  // Saturating read hit/miss counters; stores are not counted.
  always_ff @(posedge clockPulse) begin
    if (reset) begin
      hitCount  <= '0;
      missCount <= '0;
    end else begin
      if (count_hit && hitCount != 16'hFFFF) hitCount <= hitCount + 16'd1;
      if (count_miss && missCount != 16'hFFFF) missCount <= missCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_mem_stage.sv
// Self-checking bench for dcache_mem_stage: directed scenarios followed by
// random reads, stores and idle cycles, all compared against a word-level
// cache model (one remembered word address and value per line).
// Define DCACHE_STATS_EN to also check the hit/miss counters.
module tb_dcache_mem_stage;

  logic        clockPulse = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [31:0] address, writeData;
  logic        hit, stall, memRead, memWrite, memReady;
  logic [31:0] readData, memAddr, memWriteData, memReadData;
`ifdef DCACHE_STATS_EN
  logic [15:0] hitCount, missCount;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: per line, whether it holds a word, which word
  // address it holds and the word's value.
  bit          mValid [16];
  logic [31:0] mAddr  [16];
  logic [31:0] mData  [16];
  int          mHits, mMisses;

  dcache_mem_stage dut (
    .clockPulse  (clockPulse),
    .reset       (reset),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .address     (address),
    .writeData   (writeData),
    .hit         (hit),
    .readData    (readData),
    .stall       (stall),
    .memRead     (memRead),
    .memWrite    (memWrite),
    .memAddr     (memAddr),
    .memWriteData(memWriteData),
    .memReadData (memReadData),
    .memReady    (memReady)
`ifdef DCACHE_STATS_EN
    ,
    .hitCount    (hitCount),
    .missCount   (missCount)
`endif
  );

  always #5 clockPulse = ~clockPulse;

  task automatic checkOutput(input string tagName, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tagName, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clockPulse);
    #1;
  endtask

  // Compares all pipeline-facing outputs; memAddr/memWriteData only when
  // a memory request is expected to be active.
  task automatic expectBus(input string tagName, input bit eHit, input bit eStall,
                           input bit eRd, input bit eWr, input logic [31:0] eData,
                           input logic [31:0] eAddr, input logic [31:0] eWdata);
    checkOutput({tagName, ".hit"}, {31'b0, hit}, {31'b0, eHit});
    checkOutput({tagName, ".stall"}, {31'b0, stall}, {31'b0, eStall});
    checkOutput({tagName, ".memRead"}, {31'b0, memRead}, {31'b0, eRd});
    checkOutput({tagName, ".memWrite"}, {31'b0, memWrite}, {31'b0, eWr});
    checkOutput({tagName, ".readData"}, readData, eData);
    if (eRd || eWr) checkOutput({tagName, ".memAddr"}, memAddr, eAddr);
    if (eWr) checkOutput({tagName, ".memWriteData"}, memWriteData, eWdata);
  endtask

  task automatic checkStats(input string tagName);
`ifdef DCACHE_STATS_EN
    checkOutput({tagName, ".hitCount"}, {16'b0, hitCount}, mHits);
    checkOutput({tagName, ".missCount"}, {16'b0, missCount}, mMisses);
`else
    tagName = tagName;
`endif
  endtask

  task automatic clearModel();
    for (int i = 0; i < 16; i++) mValid[i] = 1'b0;
    mHits   = 0;
    mMisses = 0;
  endtask

  task automatic applyReset();
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; memReady = 1'b0;
    tick();
    reset = 1'b0;
    clearModel();
    #4;
    expectBus("reset", 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    checkOutput("reset.memAddr", memAddr, 32'h0);
    checkOutput("reset.memWriteData", memWriteData, 32'h0);
    checkStats("reset");
    tick();
  endtask

  task automatic applyIdle();
    MemRead = 1'b0; MemWrite = 1'b0;
    address = $urandom; memReady = 1'($urandom); memReadData = $urandom;
    #4;
    expectBus("idle", 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    tick();
    memReady = 1'b0;
  endtask

  // Load: a model hit answers in the same cycle; a miss costs the lookup
  // cycle, `delay` waiting FETCH cycles, the ready cycle and then the held
  // request hits with the fill data.
  task automatic applyRead(input logic [31:0] addr, input int delay, input logic [31:0] fill);
    logic [31:0] w;
    int i;
    w = {addr[31:2], 2'b00};
    i = int'(w[5:2]);
    MemRead = 1'b1; MemWrite = 1'b0; address = addr; writeData = $urandom;
    memReady = 1'b0;
    #4;
    if (mValid[i] && mAddr[i] == w) begin
      expectBus("rdHit", 1, 0, 0, 0, mData[i], 32'h0, 32'h0);
      mHits++;
      tick();
    end else begin
      expectBus("rdMiss", 0, 1, 0, 0, 32'h0, 32'h0, 32'h0);
      mMisses++;
      tick();
      for (int k = 0; k < delay; k++) begin
        memReadData = $urandom;
        #4;
        expectBus("fetchWait", 0, 1, 1, 0, 32'h0, w, 32'h0);
        tick();
      end
      memReady = 1'b1; memReadData = fill;
      #4;
      expectBus("fetchReady", 0, 1, 1, 0, 32'h0, w, 32'h0);
      tick();
      memReady = 1'b0; memReadData = $urandom;
      mValid[i] = 1'b1; mAddr[i] = w; mData[i] = fill;
      #4;
      expectBus("refill", 1, 0, 0, 0, fill, 32'h0, 32'h0);
      mHits++;
      tick();
    end
    MemRead = 1'b0;
  endtask

  // Store: lookup cycle (updates a hit line), `delay` waiting WRITE cycles,
  // the ready cycle, then one released cycle before the pipeline moves on.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                               input int delay, input bit alsoRead);
    logic [31:0] w;
    int i;
    w = {addr[31:2], 2'b00};
    i = int'(w[5:2]);
    MemRead = alsoRead; MemWrite = 1'b1; address = addr; writeData = data;
    memReady = 1'b0;
    #4;
    expectBus("wrStart", 0, 1, 0, 0, 32'h0, 32'h0, 32'h0);
    tick();
    if (mValid[i] && mAddr[i] == w) mData[i] = data;
    writeData = $urandom;
    for (int k = 0; k < delay; k++) begin
      #4;
      expectBus("wrWait", 0, 1, 0, 1, 32'h0, w, data);
      tick();
    end
    memReady = 1'b1;
    #4;
    expectBus("wrReady", 0, 1, 0, 1, 32'h0, w, data);
    tick();
    memReady = 1'b0;
    #4;
    expectBus("wrDone", 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    tick();
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  function automatic logic [31:0] randAddr();
    logic [31:0] a;
    a = {26'($urandom_range(0, 3)), 4'($urandom), 2'($urandom)};
    return a;
  endfunction

  initial begin
    reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; address = '0;
    writeData = '0; memReady = 1'b0; memReadData = '0;
    clearModel();
    #1;
    applyReset();

    // Miss then fill, repeat hit, store hit, conflict eviction.
    applyRead(32'h40, 2, 32'h0000000E);
    applyRead(32'h40, 0, 32'h0);
    checkStats("afterFirstReads");
    applyStimulus(32'h40, 32'h10, 1, 1'b0);
    applyRead(32'h40, 0, 32'h0);
    applyRead(32'h80, 1, 32'h14);
    applyRead(32'h40, 0, 32'h22);
    applyStimulus(32'h44, 32'h99, 0, 1'b1);
    applyIdle();

    // Reset in the middle of a fill: the fill is dropped and a late
    // memReady has no effect.
    applyReset();
    MemRead = 1'b1; address = 32'h40;
    tick();
    #4;
    expectBus("fetchBeforeReset", 0, 1, 1, 0, 32'h0, 32'h40, 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0; MemRead = 1'b0; memReady = 1'b1; memReadData = 32'hDEAD;
    clearModel();
    #4;
    expectBus("afterReset", 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    checkOutput("afterReset.memAddr", memAddr, 32'h0);
    tick();
    memReady = 1'b0;
    applyRead(32'h40, 0, 32'h77);
    checkStats("afterResetRead");

    // Random mix against the model.
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 3))
        0, 1: applyRead(randAddr(), $urandom_range(0, 3), $urandom);
        2: applyStimulus(randAddr(), $urandom, $urandom_range(0, 3), 1'($urandom));
        default: applyIdle();
      endcase
    end
    checkStats("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcache_mem_stage.md
Name: dcache_mem_stage

Overview:
MEM-stage data cache feeding the MEM/WB register. It supplies `hit` and `readData` to that register.
- Direct-mapped, write-through, no-write-allocate, one 32-bit word per line.
- Stalls the pipeline on read misses and on all writes while it talks to main memory over a ready handshake.

Parameters:
- NUM_LINES, 16, number of cache lines (power of two, ≥2)
- INDEX_W, 4, log2(NUM_LINES); index = address[INDEX_W+1:2]
- TAG_W, 26, 30-INDEX_W; tag = address[31:INDEX_W+2]

Ports:
- clockPulse  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- MemRead  in  1  load request from EX/MEM
- MemWrite  in  1  store request from EX/MEM
- address  in  32  byte address (EX/MEM ALUResult); bits [1:0] ignored
- writeData  in  32  store data
- hit  out  1  read hit this cycle (to MEM/WB hit)
- readData  out  32  load data (to MEM/WB readData)
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; MEM/WB captures bubble
- memRead  out  1  main-memory read request
- memWrite  out  1  main-memory write request
- memAddr  out  32  word-aligned memory address ({address[31:2],2'b00})
- memWriteData  out  32  store data to memory
- memReadData  in  32  fill data from memory
- memReady  in  1  memory completes current request this cycle

Behaviour:
- Reset (sync, active-high, any state): next edge → state IDLE, all valid bits 0, counters 0. Outputs become:
  - hit=0, stall=0, readData=0
  - memRead=0, memWrite=0, memAddr=0, memWriteData=0
  - An in-flight memory transaction is abandoned; memReady arriving later is ignored.
- FSM states: IDLE, FETCH, WRITE, WDONE.
- IDLE, no request: hit=0, stall=0, readData=0.
- IDLE, MemRead=1, MemWrite=0:
  - Hit (valid[idx] && tag match): hit=1, readData=line data, stall=0, zero-latency combinational. Stay IDLE.
  - Miss: hit=0, stall=1. Latch memAddr. Next state FETCH.
- FETCH: memRead=1, stall=1, hit=0.
  - Wait any number of cycles for memReady.
  - On memReady=1: write memReadData into line, set valid, write tag; next IDLE.
  - The held request is re-presented in IDLE and hits (1-cycle turnaround after memReady).
- IDLE, MemWrite=1 (MemWrite wins if MemRead also 1): stall=1, hit=0. Latch memAddr/memWriteData. Next WRITE.
  - Write hit: line data updated at this edge.
  - Write miss: cache unchanged.
- WRITE: memWrite=1, stall=1. On memReady=1 → WDONE.
- WDONE: stall=0, hit=0, memWrite=0. The pipeline advances past the store; next IDLE.
- memReady outside FETCH/WRITE: ignored.
- memRead and memWrite are never both 1.
- memAddr and memWriteData hold stable throughout FETCH/WRITE.
- Conflict misses: a fill overwrites the line regardless of its old tag (no dirty state, write-through).

Optional Feature:
DCACHE_STATS_EN:
- Defined: adds ports hitCount[15:0] and missCount[15:0] (outputs, reset 0).
  - hitCount +1 per IDLE read hit.
  - missCount +1 per IDLE read miss (on entering FETCH).
  - Both saturate at 16'hFFFF.
  - Writes are not counted.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package mem_stage_pkg: state encoding enum (IDLE=0, FETCH=1, WRITE=2, WDONE=3), NUM_LINES/INDEX_W/TAG_W defaults, index/tag slice helper constants.
- Sub-module dcache_array: valid/tag/data storage.
  - Combinational read port: idx → valid, tag, data.
  - One synchronous write port: we, idx, tag, data, set-valid.
  - Synchronous clear on reset.
- FSM, handshake and stats stay in dcache_mem_stage.

Test Plan:
1. Reset then MemRead, address=0x40, memReady after 3 cycles with memReadData=0x0000000E → stall=1 for 4 cycles, memRead=1, memAddr=0x40. Next cycle hit=1, readData=0x0E, stall=0.
2. Repeat read 0x40 → hit=1 same cycle, readData=0x0E, no memRead.
3. MemWrite address=0x40, writeData=0x10, memReady after 2 cycles → memWrite=1, memWriteData=0x10, stall until WDONE. Then read 0x40 hits with readData=0x10.
4. Read 0x80 (same index 0, different tag), fill 0x14 → miss, FETCH. Then read 0x40 misses again (evicted).
5. Assert reset during FETCH → memRead=0, stall=0 next edge. Later memReady ignored. Read 0x40 misses.
6. MemRead=MemWrite=1 at 0x44 → treated as write: WRITE state, hit=0. With DCACHE_STATS_EN, scenarios 1–2 give missCount=1, hitCount=2.
